// File: rtl/alarm_ringer.sv
// Alarm buzzer controller: detects the rising edge of the alarm match level and rings
// with an on/off beep pattern. Supports stop, a limited number of snoozes, and an auto-timeout.
module alarm_ringer #(
  parameter int unsigned BEEP_ON_CYCLES   = 500,
  parameter int unsigned BEEP_OFF_CYCLES  = 500,
  parameter int unsigned RING_TIMEOUT_MIN = 5,
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned MAX_SNOOZES      = 3,
  localparam int unsigned SL_W = $clog2(SNOOZE_MIN + 1),
  localparam int unsigned SU_W = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alarm_trigger,
  input  logic            minute_tick,
  input  logic            alarm_enable,
  input  logic            snooze_btn,
  input  logic            stop_btn,
  output logic            buzzer,
  output logic            ringing,
  output logic            snoozed,
  output logic [SL_W-1:0] snooze_left,
  output logic [SU_W-1:0] snoozes_used
);

  localparam int unsigned RM_W     = $clog2(RING_TIMEOUT_MIN + 1);
  localparam int unsigned BEEP_MAX = (BEEP_ON_CYCLES > BEEP_OFF_CYCLES) ? BEEP_ON_CYCLES : BEEP_OFF_CYCLES;
  localparam int unsigned BC_W     = (BEEP_MAX > 1) ? $clog2(BEEP_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_t;

  state_t          r_state, w_state_n;
  logic            r_trig_q;
  logic [RM_W-1:0] r_ring_min, w_ring_min_n, w_ring_min_inc;
  logic [SL_W-1:0] r_snooze_left, w_snooze_left_n;
  logic [SU_W-1:0] r_snoozes_used, w_snoozes_used_n;
  logic [BC_W-1:0] r_beep_cnt, w_beep_cnt_n;
  logic            r_buzzer, w_buzzer_n;
  logic            r_ringing, r_snoozed;
  logic            w_trig_rise, w_can_snooze, w_beep_restart;

  assign w_trig_rise    = alarm_trigger & ~r_trig_q;
  assign w_can_snooze   = (r_snoozes_used < SU_W'(MAX_SNOOZES));
  assign w_ring_min_inc = r_ring_min + RM_W'(1);

  // Next-state, counter and beep-phase decode
  always_comb begin
    w_state_n        = r_state;
    w_ring_min_n     = r_ring_min;
    w_snooze_left_n  = r_snooze_left;
    w_snoozes_used_n = r_snoozes_used;
    w_beep_restart   = 1'b0;
    w_buzzer_n       = 1'b0;
    w_beep_cnt_n     = '0;

    case (r_state)
      S_IDLE: begin
        if (w_trig_rise && alarm_enable) begin
          w_state_n        = S_RING;
          w_ring_min_n     = '0;
          w_snoozes_used_n = '0;
          w_beep_restart   = 1'b1;
        end
      end
      S_RING: begin
        if (stop_btn || !alarm_enable) begin
          w_state_n = S_IDLE;
        end else if (snooze_btn && w_can_snooze) begin
          w_state_n        = S_SNOOZE;
          w_snoozes_used_n = r_snoozes_used + SU_W'(1);
          w_snooze_left_n  = SL_W'(SNOOZE_MIN);
        end else if (minute_tick) begin
          if (w_ring_min_inc >= RM_W'(RING_TIMEOUT_MIN)) w_state_n = S_IDLE;
          else w_ring_min_n = w_ring_min_inc;
        end
      end
      S_SNOOZE: begin
        if (stop_btn || !alarm_enable) begin
          w_state_n = S_IDLE;
        end else if (minute_tick) begin
          if (r_snooze_left <= SL_W'(1)) begin
            w_state_n       = S_RING;
            w_snooze_left_n = '0;
            w_ring_min_n    = '0;
            w_beep_restart  = 1'b1;
          end else begin
            w_snooze_left_n = r_snooze_left - SL_W'(1);
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_state_n == S_IDLE) begin
      w_ring_min_n    = '0;
      w_snooze_left_n = '0;
    end

    // Beep phase runs only while ringing; every entry into RING starts an ON phase
    if (w_state_n == S_RING) begin
      if (w_beep_restart) begin
        w_buzzer_n = 1'b1;
      end else if (r_buzzer) begin
        if (r_beep_cnt == BC_W'(BEEP_ON_CYCLES - 1)) w_buzzer_n = 1'b0;
        else begin
          w_buzzer_n   = 1'b1;
          w_beep_cnt_n = r_beep_cnt + BC_W'(1);
        end
      end else begin
        if (r_beep_cnt == BC_W'(BEEP_OFF_CYCLES - 1)) w_buzzer_n = 1'b1;
        else w_beep_cnt_n = r_beep_cnt + BC_W'(1);
      end
    end
  end

  // State and registered outputs; trig_q resets high so a held trigger does not ring
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_trig_q       <= 1'b1;
      r_ring_min     <= '0;
      r_snooze_left  <= '0;
      r_snoozes_used <= '0;
      r_beep_cnt     <= '0;
      r_buzzer       <= 1'b0;
      r_ringing      <= 1'b0;
      r_snoozed      <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_trig_q       <= alarm_trigger;
      r_ring_min     <= w_ring_min_n;
      r_snooze_left  <= w_snooze_left_n;
      r_snoozes_used <= w_snoozes_used_n;
      r_beep_cnt     <= w_beep_cnt_n;
      r_buzzer       <= w_buzzer_n;
      r_ringing      <= (w_state_n == S_RING);
      r_snoozed      <= (w_state_n == S_SNOOZE);
    end
  end

  assign buzzer       = r_buzzer;
  assign ringing      = r_ringing;
  assign snoozed      = r_snoozed;
  assign snooze_left  = r_snooze_left;
  assign snoozes_used = r_snoozes_used;

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer: each step drives inputs, queues the outputs expected
// after the next clock edge, then pops and checks them 1ns after that edge.
module tb_alarm_ringer;

  typedef struct packed {
    logic       buzzer;
    logic       ringing;
    logic       snoozed;
    logic [1:0] left;
    logic [1:0] used;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst, trig, tick, en, snz, stp;
  logic       buzzer, ringing, snoozed;
  logic [1:0] snooze_left, snoozes_used;

  obs_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    step_no = 0;
  string tag     = "init";

  always #5 clk = ~clk;

  alarm_ringer #(
    .BEEP_ON_CYCLES  (2),
    .BEEP_OFF_CYCLES (3),
    .RING_TIMEOUT_MIN(2),
    .SNOOZE_MIN      (3),
    .MAX_SNOOZES     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alarm_trigger(trig),
    .minute_tick  (tick),
    .alarm_enable (en),
    .snooze_btn   (snz),
    .stop_btn     (stp),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozed      (snoozed),
    .snooze_left  (snooze_left),
    .snoozes_used (snoozes_used)
  );

  // One clock: drive inputs (r=rst_n, t=trigger, m=tick, e=enable, s=snooze, p=stop), expect outputs
  task automatic cyc(input logic r, t, m, e, s, p,
                     input logic b, rg, sz, input logic [1:0] l, u);
    obs_t want, got;
    rst = r; trig = t; tick = m; en = e; snz = s; stp = p;
    exp_q.push_back({b, rg, sz, l, u});
    @(posedge clk);
    #1;
    got  = {buzzer, ringing, snoozed, snooze_left, snoozes_used};
    want = exp_q.pop_front();
    step_no++;
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s step %0d: got buz=%b ring=%b snz=%b left=%0d used=%0d, expected buz=%b ring=%b snz=%b left=%0d used=%0d",
             tag, step_no, got.buzzer, got.ringing, got.snoozed, got.left, got.used,
             want.buzzer, want.ringing, want.snoozed, want.left, want.used);
    end
  endtask

  initial begin
    // reset with trigger already high, then release: no ring
    tag = "reset_trig_high";
    cyc(0,1,0,1,0,0, 0,0,0,0,0);
    cyc(0,1,0,1,0,0, 0,0,0,0,0);
    cyc(1,1,0,1,0,0, 0,0,0,0,0);
    cyc(1,1,0,1,0,0, 0,0,0,0,0);
    cyc(1,0,0,1,0,0, 0,0,0,0,0);

    // trigger rise rings; beep 1,1,0,0,0,1,1,0; held trigger does not retrigger
    tag = "ring_pattern";
    cyc(1,1,0,1,0,0, 1,1,0,0,0);
    cyc(1,1,0,1,0,0, 1,1,0,0,0);
    cyc(1,1,0,1,0,0, 0,1,0,0,0);
    cyc(1,1,0,1,0,0, 0,1,0,0,0);
    cyc(1,1,0,1,0,0, 0,1,0,0,0);
    cyc(1,1,0,1,0,0, 1,1,0,0,0);
    tag = "timeout";
    cyc(1,1,1,1,0,0, 1,1,0,0,0);
    cyc(1,1,0,1,0,0, 0,1,0,0,0);
    cyc(1,1,1,1,0,0, 0,0,0,0,0);
    cyc(1,1,0,1,0,0, 0,0,0,0,0);
    cyc(1,1,0,1,0,0, 0,0,0,0,0);
    cyc(1,0,0,1,0,0, 0,0,0,0,0);

    // snooze, count down, re-ring with buzzer on
    tag = "snooze1";
    cyc(1,1,0,1,0,0, 1,1,0,0,0);
    cyc(1,1,0,1,1,0, 0,0,1,3,1);
    cyc(1,1,0,1,0,0, 0,0,1,3,1);
    cyc(1,1,1,1,0,0, 0,0,1,2,1);
    cyc(1,1,1,1,0,0, 0,0,1,1,1);
    cyc(1,1,0,1,1,0, 0,0,1,1,1);
    cyc(1,1,1,1,0,0, 1,1,0,0,1);
    cyc(1,1,0,1,0,0, 1,1,0,0,1);

    // second snooze, then third is ignored; tick in same cycle still counts
    tag = "snooze_limit";
    cyc(1,1,0,1,1,0, 0,0,1,3,2);
    cyc(1,1,1,1,0,0, 0,0,1,2,2);
    cyc(1,1,1,1,0,0, 0,0,1,1,2);
    cyc(1,1,1,1,0,0, 1,1,0,0,2);
    cyc(1,1,0,1,1,0, 1,1,0,0,2);
    cyc(1,1,1,1,1,0, 0,1,0,0,2);
    cyc(1,1,0,1,0,0, 0,1,0,0,2);

    // stop and snooze together: stop wins; snoozes_used held in IDLE
    tag = "stop_wins";
    cyc(1,1,0,1,1,1, 0,0,0,0,2);
    cyc(1,1,0,1,0,0, 0,0,0,0,2);
    cyc(1,0,0,1,0,0, 0,0,0,0,2);

    // new event clears snoozes_used; disable stops ring; rise while disabled ignored
    tag = "enable";
    cyc(1,1,0,1,0,0, 1,1,0,0,0);
    cyc(1,1,0,0,0,0, 0,0,0,0,0);
    cyc(1,0,0,0,0,0, 0,0,0,0,0);
    cyc(1,1,0,0,0,0, 0,0,0,0,0);
    cyc(1,0,0,1,0,0, 0,0,0,0,0);

    // stop during snooze
    tag = "stop_in_snooze";
    cyc(1,1,0,1,0,0, 1,1,0,0,0);
    cyc(1,1,0,1,1,0, 0,0,1,3,1);
    cyc(1,1,0,1,0,1, 0,0,0,0,1);
    cyc(1,0,0,1,0,0, 0,0,0,0,1);

    // reset mid-snooze and mid-ring
    tag = "reset_mid";
    cyc(1,1,0,1,0,0, 1,1,0,0,0);
    cyc(1,1,0,1,1,0, 0,0,1,3,1);
    cyc(0,1,0,1,0,0, 0,0,0,0,0);
    cyc(1,1,0,1,0,0, 0,0,0,0,0);
    cyc(1,0,0,1,0,0, 0,0,0,0,0);
    cyc(1,1,0,1,0,0, 1,1,0,0,0);
    cyc(0,1,0,1,0,0, 0,0,0,0,0);
    cyc(1,1,0,1,0,0, 0,0,0,0,0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
